// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared definitions for the SPI register-write link
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;

  localparam logic SPI_WRITE = 1'b1;

  localparam logic [SPI_ADDR_W-1:0] REG_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] REG_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] REG_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] REG_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] REG_DUTY     = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode 0 initiator serialising 16-bit register-write frames
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int CS_SETUP    = 8,
  parameter int CS_HOLD     = 8,
  parameter int CS_GAP      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [SPI_ADDR_W-1:0] cmd_addr,
  input  logic [SPI_DATA_W-1:0] cmd_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  copi,
  output logic                  busy,
  output logic                  done
);

  localparam int MAX_A   = (CS_SETUP > HALF_PERIOD) ? CS_SETUP : HALF_PERIOD;
  localparam int MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_T   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // Wide enough to hold MAX_T itself, since the timer is loaded with the full count.
  localparam int TIMER_W = $clog2(MAX_T + 1);
  localparam int BIT_W   = $clog2(SPI_FRAME_W);

  localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_HALF  = TIMER_W'(HALF_PERIOD);
  localparam logic [TIMER_W-1:0] T_SETUP = TIMER_W'(CS_SETUP);
  localparam logic [TIMER_W-1:0] T_HOLD  = TIMER_W'(CS_HOLD);
  localparam logic [TIMER_W-1:0] T_GAP   = TIMER_W'(CS_GAP);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(SPI_FRAME_W - 1);

  if (HALF_PERIOD < 4 || CS_SETUP < 4 || CS_HOLD < 1 || CS_GAP < 4) begin : g_bad_params
    $error("spi_controller: timing parameter below its minimum");
  end

  spi_state_e             r_state;
  logic [SPI_FRAME_W-1:0] r_shift;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [TIMER_W-1:0]     r_timer;
  logic                   r_sclk;
  logic                   r_cs_n;
  logic                   r_busy;
  logic                   r_done;

  logic w_accept;
  logic w_expire;

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_expire  = (r_timer == T_ONE);

  // copi is the shift register MSB; clearing the register on leaving the last bit drives copi low.
  assign copi = r_shift[SPI_FRAME_W-1];
  assign sclk = r_sclk;
  assign cs_n = r_cs_n;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_timer   <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift <= {cmd_rw, cmd_addr, cmd_data};
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_timer <= T_SETUP;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_expire) begin
            r_sclk    <= 1'b1;
            r_bit_cnt <= '0;
            r_timer   <= T_HALF;
            r_state   <= ST_HIGH;
          end else begin
            r_timer <= r_timer - T_ONE;
          end
        end
        ST_HIGH: begin
          if (w_expire) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == LAST_BIT) begin
              r_shift <= '0;
              r_timer <= T_HOLD;
              r_state <= ST_HOLD;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_shift   <= {r_shift[SPI_FRAME_W-2:0], 1'b0};
              r_timer   <= T_HALF;
              r_state   <= ST_LOW;
            end
          end else begin
            r_timer <= r_timer - T_ONE;
          end
        end
        ST_LOW: begin
          if (w_expire) begin
            r_sclk  <= 1'b1;
            r_timer <= T_HALF;
            r_state <= ST_HIGH;
          end else begin
            r_timer <= r_timer - T_ONE;
          end
        end
        ST_HOLD: begin
          if (w_expire) begin
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
            r_timer <= T_GAP;
            r_state <= ST_GAP;
          end else begin
            r_timer <= r_timer - T_ONE;
          end
        end
        ST_GAP: begin
          if (w_expire) begin
            r_busy  <= 1'b0;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer - T_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - randomized self-checking bench for spi_controller
module tb_spi_controller;
  import spi_pkg::*;

  localparam int HP = 8;
  localparam int SU = 8;
  localparam int HO = 8;
  localparam int GP = 8;
  localparam int L  = SU + 31 * HP + HO;
  localparam int T  = L + GP;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       sclk;
  logic       cs_n;
  logic       copi;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // frame-level model: active flag, cycles since the accepting edge, latched frame
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [15:0] m_frame  = '0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_reg[5] = '{default: 8'h00};

  // peripheral-side observer decoded from the pins
  logic [7:0]  p_reg[5] = '{default: 8'h00};
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_copi = 1'b0;
  logic [15:0] p_bits = '0;
  logic [15:0] p_last = '0;
  int p_nbits = 0, rx_nbits = 0, n_falls = 0, cyc = 0;
  int last_fall = -1, last_rise = 0, fall_interval = 0, low_len = 0, high_len = 0, done_cnt = 0;

  spi_controller #(
    .HALF_PERIOD(HP), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .sclk(sclk), .cs_n(cs_n), .copi(copi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
  endtask

  // {cs_n, sclk, copi, busy, done, cmd_ready} derived from the frame timeline
  function automatic logic [5:0] model_pins();
    int   half;
    logic sc;
    logic co;
    if (!m_active) return 6'b100_001;
    if (m_t >= L) return {3'b100, 1'b1, (m_t == L), 1'b0};
    sc = 1'b0;
    co = 1'b0;
    if (m_t < SU) begin
      co = m_frame[15];
    end else if (m_t < SU + 31 * HP) begin
      half = (m_t - SU) / HP;
      sc   = (half % 2 == 0);
      co   = m_frame[4'(15 - (half + 1) / 2)];
    end
    return {1'b0, sc, co, 1'b1, 1'b0, 1'b0};
  endfunction

  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
      if (m_t == L) begin
        exp_q.push_back(m_frame);
        if (m_frame[15] == SPI_WRITE && m_frame[14:8] <= REG_DUTY) exp_reg[m_frame[10:8]] = m_frame[7:0];
      end
      if (m_t >= T) m_active = 1'b0;
    end else if (cmd_valid) begin
      m_active = 1'b1;
      m_t      = 0;
      m_frame  = {cmd_rw, cmd_addr, cmd_data};
    end
    #1;
    check("pins{cs_n,sclk,copi,busy,done,ready}", 32'({cs_n, sclk, copi, busy, done, cmd_ready}), 32'(model_pins()));

    if (prev_cs_n && !cs_n) begin
      n_falls++;
      if (last_fall >= 0) fall_interval = cyc - last_fall;
      high_len  = cyc - last_rise;
      last_fall = cyc;
      p_nbits   = 0;
    end
    if (!cs_n && sclk && !prev_sclk) begin
      p_bits = {p_bits[14:0], copi};
      p_nbits++;
    end
    if (!prev_cs_n && cs_n) begin
      low_len   = cyc - last_fall;
      last_rise = cyc;
      rx_nbits  = p_nbits;
      if (p_nbits == 16) begin
        p_last = p_bits;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_frame actual=0x%0h required=no frame (cycle %0d)", p_bits, cyc);
        end else begin
          check("rx_frame", 32'(p_bits), 32'(exp_q.pop_front()));
        end
        if (p_bits[15] && p_bits[14:8] <= REG_DUTY) p_reg[p_bits[10:8]] = p_bits[7:0];
      end
      p_nbits = 0;
    end
    if (copi !== prev_copi) check("copi_change_sclk_low", 32'(sclk), 32'(0));
    if (done) done_cnt++;
    prev_cs_n = cs_n;
    prev_sclk = sclk;
    prev_copi = copi;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !cmd_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy || !cmd_ready) fail_now("wait_idle");
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (n_falls < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n_falls < target) fail_now("wait_cs_fall");
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("send_ready");
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int f0;
    int n;
    rst = 1'b1; cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = REG_OUT_7_0; cmd_data = 8'hEE;
    repeat (2) @(negedge clk);
    check("reset_pins{cs_n,sclk,copi,busy,done}", 32'({cs_n, sclk, copi, busy, done}), 32'h10);
    rst = 1'b0; cmd_valid = 1'b0;
    check("ready_after_reset", 32'(cmd_ready), 32'(1));
    repeat (3) @(negedge clk);
    check("no_accept_in_reset", n_falls, 0);

    done_cnt = 0;
    send(SPI_WRITE, REG_DUTY, 8'h80);
    wait_idle();
    check("single_frame_bits", 32'(p_last), 32'h8480);
    check("single_sclk_rises", rx_nbits, 16);
    check("single_cs_low_cycles", low_len, 264);
    check("single_done_pulses", done_cnt, 1);

    f0 = n_falls;
    cmd_rw = 1'b1; cmd_addr = REG_OUT_7_0; cmd_data = 8'hA5; cmd_valid = 1'b1;
    @(negedge clk);
    wait_falls(f0 + 1);
    cmd_addr = REG_OUT_15_8; cmd_data = 8'h5A;
    wait_falls(f0 + 2);
    cmd_valid = 1'b0;
    wait_idle();
    check("b2b_accept_interval", fall_interval, 273);
    check("b2b_cs_high_ge_8", 32'(high_len >= 8), 32'(1));

    f0 = n_falls;
    send(SPI_WRITE, REG_PWM_7_0, 8'hFF);
    for (int i = 0; i < 60; i++) begin
      cmd_valid = 1'($urandom); cmd_rw = 1'($urandom);
      cmd_addr = 7'($urandom); cmd_data = 8'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_idle();
    check("busy_valid_ignored", n_falls - f0, 1);
    check("stable_frame_bits", 32'(p_last), 32'h82FF);

    send(SPI_WRITE, REG_PWM_15_8, 8'h0F);
    wait_idle();
    send(1'b0, REG_PWM_7_0, 8'h11);
    wait_idle();
    check("reg_out_7_0", 32'(p_reg[0]), 32'hA5);
    check("reg_out_15_8", 32'(p_reg[1]), 32'h5A);
    check("reg_pwm_7_0_read_no_change", 32'(p_reg[2]), 32'hFF);
    check("reg_pwm_15_8", 32'(p_reg[3]), 32'h0F);
    check("reg_duty", 32'(p_reg[4]), 32'h80);

    send(SPI_WRITE, REG_OUT_15_8, 8'h77);
    n = 0;
    while (p_nbits < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (p_nbits < 5) fail_now("wait_fifth_rise");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_{cs_n,sclk}", 32'({cs_n, sclk}), 32'h2);
    wait_idle();
    check("midreset_reg_kept", 32'(p_reg[1]), 32'h5A);
    send(SPI_WRITE, REG_OUT_7_0, 8'h3C);
    wait_idle();
    check("after_reset_write", 32'(p_reg[0]), 32'h3C);

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send(1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom));
      repeat ($urandom_range(0, 30)) begin
        cmd_valid = 1'($urandom); cmd_addr = 7'($urandom); cmd_data = 8'($urandom);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      wait_idle();
    end

    check("frames_outstanding", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) check($sformatf("final_reg_%0d", i), 32'(p_reg[i]), 32'(exp_reg[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
